shift_pipe: RTL and testbench

//  Parametrised, pipelined barrel shifter with valid/ready handshake. Generalises the 16-bit

---
 rtl/shift_pipe.sv | 132 +++++++++++++
 tb/tb_shift_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SRL/SRA/SLL, plus ROR when SHIFT_PIPE_ROT_EN is defined) with valid/ready
// handshake and a registered zero flag and tag; the whole pipe advances together on a single enable.
`timescale 1ns/1ps

module shift_pipe #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [WIDTH-1:0]         src,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic [1:0]               op,
  input  logic [TAG_W-1:0]         tag,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         res,
  output logic                     res_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int AW = $clog2(WIDTH);
  localparam int L  = (AW + REG_EVERY - 1) / REG_EVERY;
  // Shift amount is zero-padded to a whole number of register groups so every group indexes in range
  localparam int PW = L * REG_EVERY;

  localparam logic [1:0] OpSrl = 2'b00;
  localparam logic [1:0] OpSra = 2'b01;
  localparam logic [1:0] OpSll = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  function automatic logic [WIDTH-1:0] stepShift(input logic [WIDTH-1:0] d, input logic [1:0] mode,
                                                 input logic msb, input int k);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    int s;
    s    = 1 << k;
    ones = '1;
    if (mode == OpSll)
      r = d << s;
`ifdef SHIFT_PIPE_ROT_EN
    else if (mode == OpRor)
      r = (d >> s) | (d << (WIDTH - s));
`endif
    else if (mode == OpSra && msb)
      r = (d >> s) | ~(ones >> s);
    else
      r = d >> s;
    return r;
  endfunction

  logic             vldQ  [L];
  logic [WIDTH-1:0] dataQ [L];
  logic [PW-1:0]    amtQ  [L];
  logic [1:0]       opQ   [L];
  logic [TAG_W-1:0] tagQ  [L];
  logic             msbQ  [L];
  logic             zeroQ;

  logic             vldIn  [L];
  logic [WIDTH-1:0] dataIn [L];
  logic [PW-1:0]    amtIn  [L];
  logic [1:0]       opIn   [L];
  logic [TAG_W-1:0] tagIn  [L];
  logic             msbIn  [L];
  logic [WIDTH-1:0] dataD  [L];

  logic en;

  assign en       = ~vldQ[L-1] | out_rdy;
  assign in_rdy   = en;
  assign out_vld  = vldQ[L-1];
  assign res      = dataQ[L-1];
  assign res_zero = zeroQ;
  assign out_tag  = tagQ[L-1];

  always_comb begin
    vldIn[0]  = in_vld;
    dataIn[0] = src;
    amtIn[0]  = PW'(amt);
    opIn[0]   = op;
    tagIn[0]  = tag;
    msbIn[0]  = src[WIDTH-1];
    for (int p = 1; p < L; p++) begin
      vldIn[p]  = vldQ[p-1];
      dataIn[p] = dataQ[p-1];
      amtIn[p]  = amtQ[p-1];
      opIn[p]   = opQ[p-1];
      tagIn[p]  = tagQ[p-1];
      msbIn[p]  = msbQ[p-1];
    end
  end

  // Each register group applies its REG_EVERY barrel stages in ascending order of shift weight
  always_comb begin
    for (int p = 0; p < L; p++) begin
      dataD[p] = dataIn[p];
      for (int j = 0; j < REG_EVERY; j++) begin
        if (amtIn[p][p*REG_EVERY+j])
          dataD[p] = stepShift(dataD[p], opIn[p], msbIn[p], p*REG_EVERY + j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < L; p++) begin
        vldQ[p]  <= 1'b0;
        dataQ[p] <= '0;
        amtQ[p]  <= '0;
        opQ[p]   <= OpSrl;
        tagQ[p]  <= '0;
        msbQ[p]  <= 1'b0;
      end
      zeroQ <= 1'b1;
    end else if (en) begin
      for (int p = 0; p < L; p++) begin
        vldQ[p]  <= vldIn[p];
        dataQ[p] <= dataD[p];
        amtQ[p]  <= amtIn[p];
        opQ[p]   <= opIn[p];
        tagQ[p]  <= tagIn[p];
        msbQ[p]  <= msbIn[p];
      end
      zeroQ <= (dataD[L-1] == '0);
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: directed table on a 16-bit/REG_EVERY=1 instance, stream/stall/reset sequences,
// and a scored random run on a 32-bit/REG_EVERY=2 instance. Honours SHIFT_PIPE_ROT_EN like the design.
`timescale 1ns/1ps

module tb_shift_pipe;

  localparam int AL = 4;
  localparam int BL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        aInVld, aInRdy, aOutVld, aOutRdy, aResZero;
  logic [15:0] aSrc, aRes;
  logic [3:0]  aAmt;
  logic [1:0]  aOp;
  logic [3:0]  aTag, aOutTag;

  logic        bInVld, bInRdy, bOutVld, bOutRdy, bResZero;
  logic [31:0] bSrc, bRes;
  logic [4:0]  bAmt;
  logic [1:0]  bOp;
  logic [3:0]  bTag, bOutTag;

  shift_pipe #(.WIDTH(16), .REG_EVERY(1), .TAG_W(4)) dutA (
    .clk(clk), .rst(rst), .in_vld(aInVld), .in_rdy(aInRdy), .src(aSrc), .amt(aAmt), .op(aOp),
    .tag(aTag), .out_vld(aOutVld), .out_rdy(aOutRdy), .res(aRes), .res_zero(aResZero),
    .out_tag(aOutTag));

  shift_pipe #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) dutB (
    .clk(clk), .rst(rst), .in_vld(bInVld), .in_rdy(bInRdy), .src(bSrc), .amt(bAmt), .op(bOp),
    .tag(bTag), .out_vld(bOutVld), .out_rdy(bOutRdy), .res(bRes), .res_zero(bResZero),
    .out_tag(bOutTag));

  typedef struct {
    logic [15:0] src;
    logic [3:0]  amt;
    logic [1:0]  op;
    logic [3:0]  tag;
    logic [15:0] expRes;
    logic        expZero;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          cyc;
    int          stl;
  } exp_t;

  vec_t vecs [12];
  exp_t q [$];
  int nChecks = 0;
  int nFails  = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent whole-amount reference, masked to the instance width
  function automatic logic [63:0] refShift(input logic [63:0] s, input int amt, input logic [1:0] op,
                                           input int w);
    logic [63:0] mask, r;
    logic msb;
    mask = (64'd1 << w) - 64'd1;
    msb  = s[w-1];
    case (op)
      2'b00: r = s >> amt;
      2'b01: r = (s >> amt) | (msb ? (mask & ~(mask >> amt)) : 64'd0);
      2'b10: r = (s << amt) & mask;
`ifdef SHIFT_PIPE_ROT_EN
      default: r = ((s >> amt) | (s << (w - amt))) & mask;
`else
      default: r = s >> amt;
`endif
    endcase
    return r & mask;
  endfunction

  task automatic applyStimulus(input int i);
    int cyc;
    @(negedge clk);
    aSrc = vecs[i].src; aAmt = vecs[i].amt; aOp = vecs[i].op; aTag = vecs[i].tag; aInVld = 1'b1;
    #1 checkOutput($sformatf("vec%0d in_rdy", i), aInRdy, 1);
    @(posedge clk);
    #1 aInVld = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!aOutVld && cyc < 20);
    checkOutput($sformatf("vec%0d latency", i), cyc, AL);
    checkOutput($sformatf("vec%0d res", i), aRes, vecs[i].expRes);
    checkOutput($sformatf("vec%0d res_zero", i), aResZero, vecs[i].expZero);
    checkOutput($sformatf("vec%0d out_tag", i), aOutTag, vecs[i].tag);
  endtask

  // Eight beats tagged 0..7; optional window of out_rdy=0 while results are waiting
  task automatic runStream(input int stallStart, input int stallLen, input logic expectNoGap);
    int sent, got, cyc, lastGot, gaps, stray;
    logic heldValid;
    logic [15:0] heldRes;
    sent = 0; got = 0; cyc = 0; lastGot = -1; gaps = 0; heldValid = 1'b0; heldRes = '0;
    while (got < 8 && cyc < 100) begin
      @(negedge clk);
      aOutRdy = !(cyc >= stallStart && cyc < stallStart + stallLen);
      if (sent < 8) begin
        aInVld = 1'b1; aSrc = 16'(sent * 16'h1111 + 1); aAmt = 4'd1; aOp = 2'b10; aTag = 4'(sent);
      end else aInVld = 1'b0;
      #1;
      if (aOutVld && !aOutRdy) begin
        checkOutput("stall in_rdy", aInRdy, 0);
        if (heldValid) checkOutput("stall res held", aRes, heldRes);
        heldRes = aRes; heldValid = 1'b1;
      end else if (aOutVld) begin
        heldValid = 1'b0;
        checkOutput($sformatf("stream tag%0d", got), aOutTag, 4'(got));
        checkOutput($sformatf("stream res%0d", got),
                    aRes, refShift(64'(16'(got * 16'h1111 + 1)), 1, 2'b10, 16));
        if (lastGot >= 0 && cyc != lastGot + 1) gaps++;
        lastGot = cyc;
        got++;
      end
      if (aInVld && aInRdy) sent++;
      cyc++;
    end
    aInVld = 1'b0; aOutRdy = 1'b1;
    checkOutput("stream beats", got, 8);
    if (expectNoGap) checkOutput("stream gaps", gaps, 0);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (aOutVld) stray++;
    end
    checkOutput("stream no duplicates", stray, 0);
  endtask

  task automatic resetInFlight();
    int cyc, stale;
    aOutRdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      aInVld = 1'b1; aSrc = 16'hA5A5; aAmt = 4'd0; aOp = 2'b00; aTag = 4'(5 + k);
    end
    @(negedge clk);
    aInVld = 1'b0;
    cyc = 0;
    while (!aOutVld && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("pre-reset out_vld", aOutVld, 1);
    checkOutput("pre-reset res", aRes, 16'hA5A5);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst out_vld", aOutVld, 0);
    checkOutput("async rst res", aRes, 0);
    checkOutput("async rst res_zero", aResZero, 1);
    checkOutput("async rst out_tag", aOutTag, 0);
    checkOutput("async rst in_rdy", aInRdy, 1);
    aOutRdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      #1 if (aOutVld) stale++;
    end
    checkOutput("no stale after reset", stale, 0);
    applyStimulus(0);
  endtask

  task automatic runRandom();
    int sent, got, cyc, stl;
    exp_t e;
    sent = 0; got = 0; cyc = 0; stl = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      bOutRdy = ($urandom_range(0, 3) != 0);
      bInVld  = (sent < 1000) && ($urandom_range(0, 4) != 0);
      bSrc = $urandom; bAmt = 5'($urandom_range(0, 31)); bOp = 2'($urandom_range(0, 3));
      bTag = 4'(sent);
      #1;
      if (bOutVld && bOutRdy) begin
        if (q.size() == 0) checkOutput("rand unexpected beat", 1, 0);
        else begin
          e = q.pop_front();
          checkOutput("rand res", bRes, e.res);
          checkOutput("rand res_zero", bResZero, e.res == 0);
          checkOutput("rand tag", bOutTag, e.tag);
          checkOutput("rand latency", cyc - e.cyc, BL + stl - e.stl);
        end
        got++;
      end
      if (bInVld && bInRdy) begin
        q.push_back('{32'(refShift(64'(bSrc), int'(bAmt), bOp, 32)), bTag, cyc, stl});
        sent++;
      end
      if (!bInRdy) stl++;
      cyc++;
    end
    bInVld = 1'b0; bOutRdy = 1'b1;
    checkOutput("rand beats", got, 1000);
  endtask

  initial begin
    vecs[0]  = '{16'h8001, 4'd4,  2'b01, 4'd3,  16'hF800, 1'b0};
    vecs[1]  = '{16'h8001, 4'd4,  2'b00, 4'd1,  16'h0800, 1'b0};
    vecs[2]  = '{16'h8001, 4'd15, 2'b10, 4'd2,  16'h8000, 1'b0};
    vecs[3]  = '{16'h00F0, 4'd8,  2'b00, 4'd4,  16'h0000, 1'b1};
`ifdef SHIFT_PIPE_ROT_EN
    vecs[4]  = '{16'h1234, 4'd4,  2'b11, 4'd5,  16'h4123, 1'b0};
    vecs[9]  = '{16'h0001, 4'd15, 2'b11, 4'd10, 16'h0002, 1'b0};
`else
    vecs[4]  = '{16'h1234, 4'd4,  2'b11, 4'd5,  16'h0123, 1'b0};
    vecs[9]  = '{16'h0001, 4'd15, 2'b11, 4'd10, 16'h0000, 1'b1};
`endif
    vecs[5]  = '{16'h1234, 4'd0,  2'b10, 4'd6,  16'h1234, 1'b0};
    vecs[6]  = '{16'h0000, 4'd0,  2'b01, 4'd7,  16'h0000, 1'b1};
    vecs[7]  = '{16'h7FFF, 4'd15, 2'b01, 4'd8,  16'h0000, 1'b1};
    vecs[8]  = '{16'h8000, 4'd15, 2'b01, 4'd9,  16'hFFFF, 1'b0};
    vecs[10] = '{16'hABCD, 4'd8,  2'b10, 4'd11, 16'hCD00, 1'b0};
    vecs[11] = '{16'hF00F, 4'd1,  2'b01, 4'd12, 16'hF807, 1'b0};

    rst = 1'b1;
    aInVld = 1'b0; aOutRdy = 1'b0; aSrc = '0; aAmt = '0; aOp = '0; aTag = '0;
    bInVld = 1'b0; bOutRdy = 1'b1; bSrc = '0; bAmt = '0; bOp = '0; bTag = '0;
    #1;
    checkOutput("reset out_vld", aOutVld, 0);
    checkOutput("reset res", aRes, 0);
    checkOutput("reset res_zero", aResZero, 1);
    checkOutput("reset out_tag", aOutTag, 0);
    checkOutput("reset in_rdy", aInRdy, 1);
    checkOutput("reset B out_vld", bOutVld, 0);
    checkOutput("reset B res_zero", bResZero, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    aOutRdy = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(i);
    runStream(-1, 0, 1'b1);
    runStream(5, 3, 1'b0);
    resetInFlight();
    runRandom();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
